// File: rtl/metrics_seq_pkg.sv
// Shared types and bit indices for the metrics counter sequencer.
package metrics_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   localparam int unsigned CFG_W      = 8;
   localparam int unsigned CFG_EN     = 0;
   localparam int unsigned CFG_CLR    = 1;
   localparam int unsigned CFG_HWTRIG = 2;
   localparam int unsigned CFG_SINGLE = 3;
   localparam int unsigned CFG_ABORT  = 4;

   localparam int unsigned STS_W        = 8;
   localparam int unsigned STS_BUSY     = 0;
   localparam int unsigned STS_SNAPVLD  = 1;
   localparam int unsigned STS_LIMITHIT = 2;
   localparam int unsigned STS_CLRERR   = 3;
   localparam int unsigned STS_RUNSSAT  = 4;

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detection of a vector against its previous-cycle registered copy.
module edge_detect #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= '0;
      else     prev <= d;
   end

   assign rise = d & ~prev;
   assign fall = ~d & prev;

endmodule

// File: rtl/metrics_counter_sequencer.sv
// Turns the timer control byte and hw start/stop events into metrics_counter
// enable/clear, and tracks the final-count snapshot, run count and sticky status.
module metrics_counter_sequencer
   import metrics_seq_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 64,
   parameter int unsigned RUNS_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CFG_W-1:0]         cfg_i,
   input  logic                     start_evt_i,
   input  logic                     stop_evt_i,
   input  logic [COUNTER_WIDTH-1:0] limit_i,
   input  logic [COUNTER_WIDTH-1:0] cnt_i,
   output logic                     cnt_en_o,
   output logic                     cnt_clear_o,
   output logic [COUNTER_WIDTH-1:0] snap_o,
   output logic                     snap_valid_o,
   output logic [RUNS_WIDTH-1:0]    runs_o,
   output logic [1:0]               state_o,
   output logic [STS_W-1:0]         status_o
);

   seq_state_e       state, state_nxt;
   logic [CFG_W-1:0] cfg_rise, cfg_fall;
   logic             en, hw_trig, single, abort_rise, clr_rise;
   logic             limit_cond, run_stop, run_end, run_end_q;
   logic             limit_hit, clear_err, runs_sat;

   edge_detect #(.WIDTH(CFG_W)) u_cfg_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (cfg_i),
      .rise (cfg_rise),
      .fall (cfg_fall)
   );

   assign en         = cfg_i[CFG_EN];
   assign hw_trig    = cfg_i[CFG_HWTRIG];
   assign single     = cfg_i[CFG_SINGLE];
   assign abort_rise = cfg_rise[CFG_ABORT];
   assign clr_rise   = cfg_rise[CFG_CLR];
   assign limit_cond = (limit_i != '0) && (cnt_i == limit_i - COUNTER_WIDTH'(1));
   assign run_stop   = (hw_trig ? stop_evt_i : cfg_fall[CFG_EN]) | ~en | limit_cond;

   // Next-state logic; abort overrides everything.
   always_comb begin
      state_nxt = state;
      if (abort_rise) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (cfg_rise[CFG_EN]) state_nxt = hw_trig ? ARMED : RUN;
            ARMED: if (start_evt_i) state_nxt = RUN;
                   else if (!en)    state_nxt = IDLE;
            RUN:   if (run_stop) state_nxt = DONE;
            DONE:  if (single && en)       state_nxt = DONE;
                   else if (en && hw_trig) state_nxt = ARMED;
                   else                    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign run_end = (state == RUN) && (state_nxt == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         run_end_q    <= 1'b0;
         cnt_clear_o  <= 1'b0;
         snap_o       <= '0;
         snap_valid_o <= 1'b0;
         runs_o       <= '0;
         runs_sat     <= 1'b0;
         limit_hit    <= 1'b0;
         clear_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         run_end_q   <= run_end;
         cnt_clear_o <= clr_rise && (state != RUN);
         if (run_end) begin
            if (runs_o == '1) runs_sat <= 1'b1;
            else              runs_o   <= runs_o + RUNS_WIDTH'(1);
         end
         // Counter's last increment lands with the RUN->DONE edge, so sample one cycle later.
         if (run_end_q) begin
            snap_o       <= cnt_i;
            snap_valid_o <= 1'b1;
         end
         if (run_end && limit_cond) limit_hit <= 1'b1;
         if (clr_rise && (state == RUN)) clear_err <= 1'b1;
         if (clr_rise && (state != RUN)) begin
            snap_valid_o <= 1'b0;
            limit_hit    <= 1'b0;
            clear_err    <= 1'b0;
         end
      end
   end

   assign cnt_en_o = (state == RUN);
   assign state_o  = state;

   always_comb begin
      status_o               = '0;
      status_o[STS_BUSY]     = (state == ARMED) || (state == RUN);
      status_o[STS_SNAPVLD]  = snap_valid_o;
      status_o[STS_LIMITHIT] = limit_hit;
      status_o[STS_CLRERR]   = clear_err;
      status_o[STS_RUNSSAT]  = runs_sat;
   end

endmodule

// File: tb/tb_metrics_counter_sequencer.sv
// Directed bench for metrics_counter_sequencer with a modelled metrics_counter and expectation queue.
module tb_metrics_counter_sequencer;

   localparam int unsigned CW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    cfg;
   logic          start_evt, stop_evt;
   logic [CW-1:0] limit;
   logic [CW-1:0] cnt = '0;

   logic          cnt_en, cnt_clear, snap_valid;
   logic [CW-1:0] snap;
   logic [15:0]   runs;
   logic [1:0]    state;
   logic [7:0]    status;

   logic          cnt_en2, cnt_clear2, snap_valid2;
   logic [CW-1:0] snap2;
   logic [1:0]    runs2;
   logic [1:0]    state2;
   logic [7:0]    status2;

   typedef struct {
      string         tag;
      logic [CW-1:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   metrics_counter_sequencer #(.COUNTER_WIDTH(CW), .RUNS_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .cfg_i(cfg), .start_evt_i(start_evt), .stop_evt_i(stop_evt),
      .limit_i(limit), .cnt_i(cnt), .cnt_en_o(cnt_en), .cnt_clear_o(cnt_clear),
      .snap_o(snap), .snap_valid_o(snap_valid), .runs_o(runs), .state_o(state), .status_o(status)
   );

   metrics_counter_sequencer #(.COUNTER_WIDTH(CW), .RUNS_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst), .cfg_i(cfg), .start_evt_i(start_evt), .stop_evt_i(stop_evt),
      .limit_i(limit), .cnt_i(cnt), .cnt_en_o(cnt_en2), .cnt_clear_o(cnt_clear2),
      .snap_o(snap2), .snap_valid_o(snap_valid2), .runs_o(runs2), .state_o(state2), .status_o(status2)
   );

   // metrics_counter model; deliberately not reset by rst.
   always_ff @(posedge clk) begin
      if (cnt_clear)   cnt <= '0;
      else if (cnt_en) cnt <= cnt + 64'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [CW-1:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [CW-1:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      int n_en;
      int guard;
      rst = 1'b1; cfg = 8'h00; start_evt = 1'b0; stop_evt = 1'b0; limit = '0;
      repeat (3) step();
      expect_val("rst_state", 0);      observe(64'(state));
      expect_val("rst_en", 0);         observe(64'(cnt_en));
      expect_val("rst_status", 0);     observe(64'(status));
      expect_val("rst_runs", 0);       observe(64'(runs));
      rst = 1'b0;
      step();

      // 1: software-gated run of 10 cycles
      cfg = 8'h01;
      n_en = 0;
      step();
      expect_val("sw_run_state", 2);   observe(64'(state));
      if (cnt_en) n_en++;
      repeat (9) begin
         step();
         if (cnt_en) n_en++;
      end
      cfg = 8'h00;
      step();
      expect_val("sw_done_state", 3);  observe(64'(state));
      if (cnt_en) n_en++;
      step();
      expect_val("sw_en_cycles", 10);  observe(64'(n_en));
      expect_val("sw_snap", 10);       observe(snap);
      expect_val("sw_snap_valid", 1);  observe(64'(snap_valid));
      expect_val("sw_runs", 1);        observe(64'(runs));
      expect_val("sw_idle", 0);        observe(64'(state));

      // 4a: clear in IDLE pulses once and drops snap_valid, keeps data
      cfg = 8'h02;
      step();
      expect_val("clr_pulse", 1);      observe(64'(cnt_clear));
      expect_val("clr_snap_valid", 0); observe(64'(snap_valid));
      step();
      expect_val("clr_pulse_end", 0);  observe(64'(cnt_clear));
      expect_val("clr_snap_kept", 10); observe(snap);
      expect_val("clr_runs_kept", 1);  observe(64'(runs));
      expect_val("clr_cnt", 0);        observe(cnt);
      cfg = 8'h00;
      step();

      // 2: hardware-triggered run of 7 cycles
      cfg = 8'h05;
      step();
      expect_val("hw_armed", 1);       observe(64'(state));
      expect_val("hw_busy", 1);        observe(64'(status[0]));
      start_evt = 1'b1;
      step();
      start_evt = 1'b0;
      expect_val("hw_run", 2);         observe(64'(state));
      repeat (6) step();
      stop_evt = 1'b1;
      step();
      stop_evt = 1'b0;
      expect_val("hw_done", 3);        observe(64'(state));
      step();
      expect_val("hw_rearmed", 1);     observe(64'(state));
      expect_val("hw_snap", 7);        observe(snap);
      expect_val("hw_runs", 2);        observe(64'(runs));

      // 3: cycle limit with single-shot hold
      cfg = 8'h00;
      step();
      cfg = 8'h02;
      step();
      step();
      cfg = 8'h00;
      limit = 64'd5;
      step();
      cfg = 8'h09;
      step();
      expect_val("lim_run", 2);        observe(64'(state));
      guard = 0;
      while (state != 2'd3 && guard < 20) begin
         step();
         guard++;
      end
      expect_val("lim_reached_done", 3); observe(64'(state));
      step();
      expect_val("lim_hold", 3);       observe(64'(state));
      expect_val("lim_snap", 5);       observe(snap);
      expect_val("lim_sticky", 1);     observe(64'(status[2]));
      repeat (3) step();
      expect_val("lim_hold_more", 3);  observe(64'(state));
      cfg = 8'h00;
      limit = '0;
      step();
      expect_val("lim_release", 0);    observe(64'(state));
      expect_val("lim_runs", 3);       observe(64'(runs));

      // 4b: clear rise during RUN gives no pulse and sets clear_err
      cfg = 8'h01;
      step();
      cfg = 8'h03;
      step();
      expect_val("clr_run_nopulse", 0); observe(64'(cnt_clear));
      expect_val("clr_run_err", 1);    observe(64'(status[3]));
      expect_val("clr_run_state", 2);  observe(64'(state));
      cfg = 8'h00;
      step();
      step();
      cfg = 8'h02;
      step();
      expect_val("clr2_pulse", 1);     observe(64'(cnt_clear));
      expect_val("clr2_status", 0);    observe(64'(status[3:1]));
      expect_val("clr2_runs", 4);      observe(64'(runs));
      cfg = 8'h00;
      step();

      // 5: start+stop together in ARMED, abort, reset mid-run
      cfg = 8'h05;
      step();
      start_evt = 1'b1; stop_evt = 1'b1;
      step();
      start_evt = 1'b0; stop_evt = 1'b0;
      expect_val("ss_run", 2);         observe(64'(state));
      step();
      expect_val("ss_stop_dropped", 2); observe(64'(state));
      cfg = 8'h15;
      step();
      expect_val("abort_idle", 0);     observe(64'(state));
      step();
      expect_val("abort_runs", 4);     observe(64'(runs));
      cfg = 8'h00;
      step();
      cfg = 8'h01;
      step();
      expect_val("rr_run", 2);         observe(64'(state));
      rst = 1'b1; cfg = 8'h00;
      step();
      expect_val("rr_state", 0);       observe(64'(state));
      expect_val("rr_en", 0);          observe(64'(cnt_en));
      expect_val("rr_snap", 0);        observe(snap);
      expect_val("rr_runs", 0);        observe(64'(runs));
      expect_val("rr_status", 0);      observe(64'(status));
      rst = 1'b0;
      step();

      // 6: five runs; narrow instance saturates
      for (int i = 0; i < 5; i++) begin
         cfg = 8'h01;
         step();
         step();
         cfg = 8'h00;
         step();
         step();
      end
      expect_val("sat_runs_wide", 5);  observe(64'(runs));
      expect_val("sat_wide_flag", 0);  observe(64'(status[4]));
      expect_val("sat_runs", 3);       observe(64'(runs2));
      expect_val("sat_flag", 1);       observe(64'(status2[4]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
